// File: rtl/and_1_if.sv
// Signal bundle for the and_1 cell: operands and counter clear in, gate and monitor outputs back.
interface and_1_if #(
    parameter int CNT_W = 16
);
    logic             A;
    logic             B;
    logic             clr_cnt;
    logic             Q;
    logic             Q_reg;
    logic             q_rise;
    logic             q_fall;
    logic [CNT_W-1:0] hi_cnt;

    modport master (
        output A, B, clr_cnt,
        input  Q, Q_reg, q_rise, q_fall, hi_cnt
    );

    modport slave (
        input  A, B, clr_cnt,
        output Q, Q_reg, q_rise, q_fall, hi_cnt
    );
endinterface

// File: rtl/and_1.sv
// Two-input AND with a clocked monitor: registered copy, edge pulses, saturating high-cycle count.
// Define AND1_GLITCH_FILTER_EN to require FILT_LEN consecutive differing edges before Q_reg moves.
module and_1 #(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    and_1_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             q_next;
    logic             q_reg;
    logic             q_prev_reg;
    logic             q_rise_reg;
    logic             q_fall_reg;
    logic [CNT_W-1:0] hi_cnt_reg;

    // The gate itself never touches clk or rst_n.
    assign bus.Q = bus.A & bus.B;

`ifdef AND1_GLITCH_FILTER_EN
    localparam int               RUN_W    = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);

    logic [RUN_W-1:0] run_reg;
    logic             differs;

    assign differs = (bus.Q != q_reg);
    assign q_next  = (differs && run_reg == RUN_LAST) ? bus.Q : q_reg;

    // Run counter restarts whenever Q agrees with Q_reg or a change is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg <= '0;
        end else if (!differs || run_reg == RUN_LAST) begin
            run_reg <= '0;
        end else begin
            run_reg <= run_reg + 1'b1;
        end
    end
`else
    assign q_next = bus.Q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg      <= 1'b0;
            q_prev_reg <= 1'b0;
            q_rise_reg <= 1'b0;
            q_fall_reg <= 1'b0;
            hi_cnt_reg <= '0;
        end else begin
            q_reg      <= q_next;
            q_prev_reg <= q_reg;
            // Pulses trail the Q_reg change by one cycle.
            q_rise_reg <= q_reg & ~q_prev_reg;
            q_fall_reg <= ~q_reg & q_prev_reg;
            if (bus.clr_cnt) begin
                hi_cnt_reg <= '0;
            end else if (q_reg && hi_cnt_reg != CNT_MAX) begin
                hi_cnt_reg <= hi_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.Q_reg  = q_reg;
    assign bus.q_rise = q_rise_reg;
    assign bus.q_fall = q_fall_reg;
    assign bus.hi_cnt = hi_cnt_reg;
endmodule

// File: tb/tb_and_1.sv
// Directed-vector bench for and_1 with a 3-bit counter; filter vectors run when AND1_GLITCH_FILTER_EN is defined.
module tb_and_1;
    localparam int CNT_W    = 3;
    localparam int FILT_LEN = 4;

    logic clk     = 1'b0;
    logic clk_run = 1'b0;
    logic rst_n   = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    and_1_if #(.CNT_W(CNT_W)) bus_if ();

    and_1 #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [1:0] ab_tab [4];
        logic       q_tab  [4];
        logic       rise_tab [4];
        logic       fall_tab [4];

        ab_tab = '{2'b00, 2'b10, 2'b01, 2'b11};
        q_tab  = '{1'b0, 1'b0, 1'b0, 1'b1};
        bus_if.A       = 1'b0;
        bus_if.B       = 1'b0;
        bus_if.clr_cnt = 1'b0;

        // Reset held, clock idle: gate still follows A & B.
        for (int i = 0; i < 4; i++) begin
            bus_if.A = ab_tab[i][1];
            bus_if.B = ab_tab[i][0];
            #10;
            chk($sformatf("gate_AB%0b", ab_tab[i]), 32'(bus_if.Q), 32'(q_tab[i]));
        end
        chk("rst_Q_reg",  32'(bus_if.Q_reg),  32'd0);
        chk("rst_q_rise", 32'(bus_if.q_rise), 32'd0);
        chk("rst_q_fall", 32'(bus_if.q_fall), 32'd0);
        chk("rst_hi_cnt", 32'(bus_if.hi_cnt), 32'd0);

        bus_if.A = 1'b0;
        bus_if.B = 1'b0;
        clk_run  = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_Q_reg", 32'(bus_if.Q_reg), 32'd0);

`ifndef AND1_GLITCH_FILTER_EN
        // Rise then fall, pulses one cycle after Q_reg moves.
        bus_if.A = 1'b1;
        bus_if.B = 1'b1;
        tick();
        chk("e1_Q_reg",  32'(bus_if.Q_reg),  32'd1);
        chk("e1_q_rise", 32'(bus_if.q_rise), 32'd0);
        chk("e1_hi_cnt", 32'(bus_if.hi_cnt), 32'd0);
        tick();
        chk("e2_q_rise", 32'(bus_if.q_rise), 32'd1);
        chk("e2_hi_cnt", 32'(bus_if.hi_cnt), 32'd1);
        bus_if.A = 1'b0;
        tick();
        chk("e3_Q_reg",  32'(bus_if.Q_reg),  32'd0);
        chk("e3_q_rise", 32'(bus_if.q_rise), 32'd0);
        chk("e3_q_fall", 32'(bus_if.q_fall), 32'd0);
        chk("e3_hi_cnt", 32'(bus_if.hi_cnt), 32'd2);
        tick();
        chk("e4_q_fall", 32'(bus_if.q_fall), 32'd1);
        chk("e4_hi_cnt", 32'(bus_if.hi_cnt), 32'd2);
        tick();
        chk("e5_q_fall", 32'(bus_if.q_fall), 32'd0);

        // Saturation at 7 for a 3-bit counter.
        bus_if.clr_cnt = 1'b1;
        tick();
        chk("clr_idle", 32'(bus_if.hi_cnt), 32'd0);
        bus_if.clr_cnt = 1'b0;
        bus_if.A = 1'b1;
        tick();
        chk("sat_start", 32'(bus_if.hi_cnt), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("sat_%0d", i), 32'(bus_if.hi_cnt), 32'((i > 7) ? 7 : i));
        end

        // Clear wins over increment, counting resumes next edge.
        bus_if.clr_cnt = 1'b1;
        tick();
        chk("clr_prio", 32'(bus_if.hi_cnt), 32'd0);
        bus_if.clr_cnt = 1'b0;
        tick();
        chk("clr_next1", 32'(bus_if.hi_cnt), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_hi", 32'(bus_if.hi_cnt), 32'd5);

        // Async reset between edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_Q_reg",  32'(bus_if.Q_reg),  32'd0);
        chk("arst_q_rise", 32'(bus_if.q_rise), 32'd0);
        chk("arst_q_fall", 32'(bus_if.q_fall), 32'd0);
        chk("arst_hi_cnt", 32'(bus_if.hi_cnt), 32'd0);
        chk("arst_Q",      32'(bus_if.Q),      32'd1);

        // Q toggling every cycle gives alternating pulses.
        tick();
        rst_n    = 1'b1;
        bus_if.A = 1'b0;
        tick();
        rise_tab = '{1'b0, 1'b1, 1'b0, 1'b1};
        fall_tab = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            bus_if.A = ~bus_if.A;
            tick();
            chk($sformatf("tog%0d_rise", i), 32'(bus_if.q_rise), 32'(rise_tab[i]));
            chk($sformatf("tog%0d_fall", i), 32'(bus_if.q_fall), 32'(fall_tab[i]));
        end
`else
        // 3-cycle pulse is swallowed.
        bus_if.A = 1'b1;
        bus_if.B = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("f3_e%0d", i), 32'(bus_if.Q_reg), 32'd0);
        end
        bus_if.A = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            chk($sformatf("f3_post%0d", i), 32'(bus_if.Q_reg), 32'd0);
        end
        chk("f3_rise", 32'(bus_if.q_rise), 32'd0);

        // 4-cycle pulse is accepted on the 4th edge.
        bus_if.A = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("f4_e%0d", i), 32'(bus_if.Q_reg), 32'((i == 4) ? 1 : 0));
        end
        bus_if.A = 1'b0;
        tick();
        chk("f4_rise",  32'(bus_if.q_rise), 32'd1);
        chk("f4_hold",  32'(bus_if.Q_reg),  32'd1);
        chk("f4_hicnt", 32'(bus_if.hi_cnt), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
